// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline writeback, MDU result and register-file write signals
// shared between the write-port arbiter and its environment.
interface wb_port_arbiter_if;
    logic        p_we;
    logic        p_dst_sel;
    logic [4:0]  p_rt;
    logic [4:0]  p_rd;
    logic [31:0] p_wdata;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;

    modport slave (
        input  p_we,
        input  p_dst_sel,
        input  p_rt,
        input  p_rd,
        input  p_wdata,
        input  m_valid,
        input  m_addr,
        input  m_wdata,
        output m_ready,
        output stall,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output rf_src
    );

    modport master (
        output p_we,
        output p_dst_sel,
        output p_rt,
        output p_rd,
        output p_wdata,
        output m_valid,
        output m_addr,
        output m_wdata,
        input  m_ready,
        input  stall,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  rf_src
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// MDU results: pipeline has priority, a starvation counter forces an MDU slot.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam logic [0:0]       ST_NORMAL = 1'b0;
    localparam logic [0:0]       ST_FORCE  = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic        pipe_win;
    logic        mdu_win;
    logic        win_any;
    logic [4:0]  p_addr;
    logic [4:0]  win_addr;
    logic [31:0] win_data;
    logic        m_ready_c;
    logic        stall_c;

    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        rf_src_q;

    assign p_addr  = bus.p_dst_sel ? bus.p_rd : bus.p_rt;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        pipe_win  = 1'b0;
        mdu_win   = 1'b0;
        m_ready_c = 1'b0;
        stall_c   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (!reset) begin
            if (state_q == ST_FORCE) begin
                // Forced MDU slot: pipeline freezes and re-presents next cycle.
                stall_c   = 1'b1;
                m_ready_c = bus.m_valid;
                mdu_win   = bus.m_valid;
                state_d   = ST_NORMAL;
                cnt_d     = '0;
            end else if (bus.p_we) begin
                pipe_win = 1'b1;
                if (bus.m_valid) begin
                    if (cnt_q != LIMIT) begin
                        cnt_d = cnt_inc;
                    end
                    if (cnt_inc == LIMIT) begin
                        state_d = ST_FORCE;
                    end
                end
            end else if (bus.m_valid) begin
                mdu_win   = 1'b1;
                m_ready_c = 1'b1;
                cnt_d     = '0;
            end
        end
    end

    assign win_any  = pipe_win | mdu_win;
    assign win_addr = mdu_win ? bus.m_addr : p_addr;
    assign win_data = mdu_win ? bus.m_wdata : bus.p_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_NORMAL;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Writes to $0 still win arbitration but never enable the port.
            rf_we_q <= win_any && (win_addr != 5'd0);
            if (win_any) begin
                rf_waddr_q <= win_addr;
                rf_wdata_q <= win_data;
                rf_src_q   <= mdu_win;
            end
        end
    end

    assign bus.m_ready  = m_ready_c;
    assign bus.stall    = stall_c;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rf_src   = rf_src_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, both write paths, starvation
// guard, $0 writes, back-to-back grants and reset during a forced slot.
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W       (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.p_we      = 1'b0;
        bus.p_dst_sel = 1'b0;
        bus.p_rt      = 5'd0;
        bus.p_rd      = 5'd0;
        bus.p_wdata   = 32'd0;
        bus.m_valid   = 1'b0;
        bus.m_addr    = 5'd0;
        bus.m_wdata   = 32'd0;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b1;
        bus.p_rd      = 5'd7;
        bus.p_rt      = 5'd6;
        bus.p_wdata   = 32'h55;
        bus.m_valid   = 1'b1;
        bus.m_addr    = 5'd12;
        bus.m_wdata   = 32'h66;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b00)
            $display("FAIL reset_comb0: stall/m_ready=%b want 00", {bus.stall, bus.m_ready});
        else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== 39'd0)
                $display("FAIL reset_regs%0d: we=%b addr=%0d data=%h src=%b want all 0", i,
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
            else passed++;
            total++;
            if ({bus.stall, bus.m_ready} !== 2'b00)
                $display("FAIL reset_comb%0d: stall/m_ready=%b want 00", i + 1,
                         {bus.stall, bus.m_ready});
            else passed++;
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (bus.stall !== 1'b0) $display("FAIL reset_release: stall=%b want 0", bus.stall);
        else passed++;
        tick();
        total++;
        if (bus.rf_we !== 1'b0) $display("FAIL reset_idle_we: rf_we=%b want 0", bus.rf_we);
        else passed++;
    endtask

    task automatic test_pipe_write;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b1;
        bus.p_rd      = 5'd8;
        bus.p_rt      = 5'd9;
        bus.p_wdata   = 32'hDEADBEEF;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b00)
            $display("FAIL pipe_comb: stall/m_ready=%b want 00", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd8, 32'hDEADBEEF, 1'b0})
            $display("FAIL pipe_rd: we=%b addr=%0d data=%h src=%b want 1 8 deadbeef 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        bus.p_dst_sel = 1'b0;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd9, 32'hDEADBEEF, 1'b0})
            $display("FAIL pipe_rt: we=%b addr=%0d data=%h src=%b want 1 9 deadbeef 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        idle_inputs();
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd9, 32'hDEADBEEF})
            $display("FAIL pipe_hold: we=%b addr=%0d data=%h want 0 9 deadbeef",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        else passed++;
    endtask

    task automatic test_mdu_write;
        bus.m_valid = 1'b1;
        bus.m_addr  = 5'd31;
        bus.m_wdata = 32'h1234;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b01)
            $display("FAIL mdu_comb: stall/m_ready=%b want 01", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd31, 32'h1234, 1'b1})
            $display("FAIL mdu_write: we=%b addr=%0d data=%h src=%b want 1 31 1234 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
    endtask

    task automatic test_starve;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b1;
        bus.m_valid   = 1'b1;
        bus.m_addr    = 5'd17;
        bus.m_wdata   = 32'hAAAA0017;
        for (int i = 0; i < 4; i++) begin
            bus.p_rd    = 5'(i + 1);
            bus.p_wdata = 32'h100 + 32'(i);
            #1;
            total++;
            if ({bus.stall, bus.m_ready} !== 2'b00)
                $display("FAIL starve_lose%0d: stall/m_ready=%b want 00", i,
                         {bus.stall, bus.m_ready});
            else passed++;
            tick();
            total++;
            if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !==
                {1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0})
                $display("FAIL starve_pipe%0d: we=%b addr=%0d data=%h src=%b want 1 %0d %h 0", i,
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src, i + 1, 32'h100 + i);
            else passed++;
        end
        bus.p_rd    = 5'd20;
        bus.p_wdata = 32'h200;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b11)
            $display("FAIL starve_force: stall/m_ready=%b want 11", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        bus.m_valid = 1'b0;
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd17, 32'hAAAA0017, 1'b1})
            $display("FAIL starve_mdu: we=%b addr=%0d data=%h src=%b want 1 17 aaaa0017 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b00)
            $display("FAIL starve_resume: stall/m_ready=%b want 00", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd20, 32'h200, 1'b0})
            $display("FAIL starve_repipe: we=%b addr=%0d data=%h src=%b want 1 20 200 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_zero_dst;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b0;
        bus.p_rt      = 5'd0;
        bus.p_rd      = 5'd3;
        bus.p_wdata   = 32'h77;
        #1;
        total++;
        if (bus.stall !== 1'b0) $display("FAIL zero_pipe_stall: stall=%b want 0", bus.stall);
        else passed++;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_src} !== {1'b0, 5'd0, 1'b0})
            $display("FAIL zero_pipe: we=%b addr=%0d src=%b want 0 0 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_src);
        else passed++;
        idle_inputs();
        bus.m_valid = 1'b1;
        bus.m_addr  = 5'd0;
        bus.m_wdata = 32'h88;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b01)
            $display("FAIL zero_mdu_ready: stall/m_ready=%b want 01", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_src} !== {1'b0, 5'd0, 1'b1})
            $display("FAIL zero_mdu: we=%b addr=%0d src=%b want 0 0 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_src);
        else passed++;
    endtask

    task automatic test_back_to_back;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b1;
        bus.p_rd      = 5'd3;
        bus.p_wdata   = 32'h3333;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd3, 32'h3333, 1'b0})
            $display("FAIL b2b_a: we=%b addr=%0d data=%h src=%b want 1 3 3333 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        bus.p_we    = 1'b0;
        bus.m_valid = 1'b1;
        bus.m_addr  = 5'd4;
        bus.m_wdata = 32'h4444;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd4, 32'h4444, 1'b1})
            $display("FAIL b2b_b: we=%b addr=%0d data=%h src=%b want 1 4 4444 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        bus.m_valid   = 1'b0;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b0;
        bus.p_rt      = 5'd6;
        bus.p_wdata   = 32'h6666;
        tick();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd6, 32'h6666, 1'b0})
            $display("FAIL b2b_c: we=%b addr=%0d data=%h src=%b want 1 6 6666 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_force_reset;
        bus.p_we      = 1'b1;
        bus.p_dst_sel = 1'b0;
        bus.p_rt      = 5'd3;
        bus.p_wdata   = 32'h3030;
        bus.m_valid   = 1'b1;
        bus.m_addr    = 5'd9;
        bus.m_wdata   = 32'h9090;
        for (int i = 0; i < 4; i++) tick();
        #1;
        total++;
        if (bus.stall !== 1'b1) $display("FAIL frst_in_force: stall=%b want 1", bus.stall);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b00)
            $display("FAIL frst_comb: stall/m_ready=%b want 00", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        reset = 1'b0;
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_src} !== {1'b0, 5'd0, 1'b0})
            $display("FAIL frst_regs: we=%b addr=%0d src=%b want 0 0 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_src);
        else passed++;
        // Counter restarts from zero: four more lost cycles before the next forced slot.
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({bus.stall, bus.m_ready} !== 2'b00)
                $display("FAIL frst_lose%0d: stall/m_ready=%b want 00", i,
                         {bus.stall, bus.m_ready});
            else passed++;
            tick();
        end
        total++;
        if ({bus.stall, bus.m_ready} !== 2'b11)
            $display("FAIL frst_reforce: stall/m_ready=%b want 11", {bus.stall, bus.m_ready});
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src} !== {1'b1, 5'd9, 32'h9090, 1'b1})
            $display("FAIL frst_mdu: we=%b addr=%0d data=%h src=%b want 1 9 9090 1",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        else passed++;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_pipe_write();
        test_mdu_write();
        test_starve();
        test_zero_dst();
        test_back_to_back();
        test_force_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WB) and the multiply/divide unit (MDU) result return.
- Owns the rt/rd destination-address select for the pipeline path. Gives the pipeline fixed priority, with a starvation guard that stalls the pipeline for one cycle so a waiting MDU result can retire.
- Register-file write outputs are registered, with one cycle of latency.

Parameters:
STARVE_LIMIT, 4, number of consecutive lost MDU arbitration cycles before a forced MDU slot; legal range 1..15
CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
p_we  input  1  pipeline WB write request for this cycle
p_dst_sel  input  1  RegDst: 1 selects p_rd, 0 selects p_rt
p_rt  input  5  rt field of the WB instruction
p_rd  input  5  rd field of the WB instruction
p_wdata  input  32  pipeline write data
m_valid  input  1  MDU result valid; held until accepted
m_addr  input  5  MDU destination register
m_wdata  input  32  MDU write data
m_ready  output  1  MDU result accepted this cycle (combinational)
stall  output  1  pipeline must freeze WB and re-present next cycle (combinational)
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  32  register-file write data (registered)
rf_src  output  1  source of the current write: 0 = pipeline, 1 = MDU (registered)

Behaviour:
- Pipeline address is p_dst_sel ? p_rd : p_rt.
- Reset (synchronous, takes priority over all other behaviour) clears the following: state=NORMAL, cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0. If reset is asserted mid-arbitration, the pending MDU result is not accepted that cycle.
- Combinational outputs during reset: m_ready=0 and stall=0.
- FSM states: NORMAL, FORCE.
- NORMAL, p_we=1:
  - The pipeline wins and m_ready=0.
  - If m_valid=1, cnt increments. If cnt+1 == STARVE_LIMIT, the next state is FORCE.
- NORMAL, p_we=0, m_valid=1: the MDU wins, m_ready=1, cnt clears to 0.
- NORMAL, neither requester active: no write and cnt holds.
- FORCE:
  - stall=1 and m_ready=m_valid. Any p_we is ignored this cycle; the pipeline re-presents next cycle because of the stall.
  - The next state is NORMAL and cnt clears to 0.
  - If m_valid=0 in FORCE (protocol violation), the block still stalls, performs no write, and returns to NORMAL.
- stall=0 in NORMAL.
- Write register, loaded on every non-reset edge:
  - rf_we = (winner exists) && (winner address != 0).
  - rf_waddr and rf_wdata come from the winner, or hold their previous value when there is no winner.
  - rf_src is 1 if the MDU won and 0 otherwise (holds when there is no winner).
- Writes to $0 complete their handshake: m_ready pulses for the MDU and the pipeline is not stalled, but rf_we stays 0.
- Latency: a grant in cycle N gives rf_we/rf_waddr/rf_wdata valid in cycle N+1, for exactly one cycle per grant.
- Back-to-back grants are allowed every cycle, and there are no bubbles between winners.
- An MDU result accepted in cycle N must be deasserted or replaced by the MDU in cycle N+1. The arbiter does not track result identity.
- The counter saturates at STARVE_LIMIT and never wraps.
- With STARVE_LIMIT=1, a single lost cycle triggers FORCE next cycle.

Test Plan:
- Reset held 2 cycles with p_we=1, m_valid=1 -> rf_we=0, rf_waddr=0, m_ready=0, stall=0 throughout; state NORMAL after release.
- p_we=1, p_dst_sel=1, p_rd=5'd8, p_rt=5'd9, p_wdata=32'hDEADBEEF -> next cycle rf_we=1, rf_waddr=8, rf_wdata=32'hDEADBEEF, rf_src=0. Repeat with p_dst_sel=0 -> rf_waddr=9.
- p_we=0, m_valid=1, m_addr=5'd31, m_wdata=32'h1234 -> m_ready=1 same cycle; next cycle rf_we=1, rf_waddr=31, rf_src=1.
- STARVE_LIMIT=4, p_we=1 every cycle, m_valid=1 held -> m_ready=0 and pipeline writes for 4 cycles. Cycle 5: stall=1, m_ready=1. Cycle 6: rf_src=1 write. Pipeline writes resume from cycle 6 grant onward.
- p_we=1 with p_rt=0 (p_dst_sel=0); then m_valid=1, m_addr=0 with p_we=0 -> rf_we=0 in both following cycles; m_ready=1 for the MDU request.
- In FORCE, assert reset -> next cycle state NORMAL, cnt=0, stall=0, rf_we=0; MDU result not accepted until a later grant.
